// File: rtl/main_mul_rescale_stage.sv
// Issue/retire stage around an external pipelined unsigned multiplier.
// Operands go straight to the multiplier; a valid pipe tracks its latency, each
// product is rescaled Q(2F)->Q(F) with round-half-up and saturation, and results
// are queued in a credit-protected FIFO towards a valid/ready consumer.
module main_mul_rescale_stage #(
    parameter int unsigned A_W        = 42,
    parameter int unsigned B_W        = 33,
    parameter int unsigned P_W        = 75,
    parameter int unsigned MUL_LAT    = 1,
    parameter int unsigned FRAC_BITS  = 32,
    parameter int unsigned OUT_W      = 42,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    output logic             mul_ce,
    output logic [A_W-1:0]   mul_din0,
    output logic [B_W-1:0]   mul_din1,
    input  logic [P_W-1:0]   mul_dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             busy
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CRD_W = $clog2(FIFO_DEPTH + MUL_LAT + 1);
    localparam int unsigned R_W   = P_W + 1;
    localparam int unsigned RES_W = OUT_W + 1;
    localparam logic [R_W-1:0] RND =
        (FRAC_BITS > 0) ? (R_W'(1) << (FRAC_BITS - 1)) : '0;

    logic [MUL_LAT-1:0] vld_pipe_q, vld_pipe_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [RES_W-1:0]   mem_q [FIFO_DEPTH];
    logic [RES_W-1:0]   mem_d [FIFO_DEPTH];
    logic [RES_W-1:0]   head_q, head_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               ce_q;

    logic               accept_c, push_c, pop_c;
    logic [CRD_W-1:0]   pend_c;
    logic [R_W-1:0]     rnd_sum_c, quo_c;
    logic               sat_c;
    logic [OUT_W-1:0]   res_data_c;

    // Operands feed the multiplier directly; enable is on whenever out of reset.
    assign mul_din0  = in_a;
    assign mul_din1  = in_b;
    assign mul_ce    = ce_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = head_q[OUT_W-1:0];
    assign out_sat   = head_q[OUT_W];
    assign busy      = busy_q;

    // Round-half-up rescale of the product with saturation to OUT_W bits.
    always_comb begin
        rnd_sum_c  = R_W'(mul_dout) + RND;
        quo_c      = rnd_sum_c >> FRAC_BITS;
        sat_c      = (quo_c >> OUT_W) != '0;
        res_data_c = sat_c ? '1 : OUT_W'(quo_c);
    end

    // Next-state for the valid pipe, FIFO and registered flags.
    always_comb begin
        accept_c    = in_valid & in_ready_q;
        push_c      = vld_pipe_q[MUL_LAT-1];
        pop_c       = out_valid_q & out_ready;
        vld_pipe_d  = '0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        mem_d       = mem_q;
        head_d      = head_q;
        pend_c      = '0;

        vld_pipe_d[0] = accept_c;
        for (int i = 1; i < int'(MUL_LAT); i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
        end

        if (push_c) begin
            mem_d[wr_ptr_q] = {sat_c, res_data_c};
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Head register holds its last value while the FIFO is empty.
        if (count_d != '0) begin
            head_d = mem_d[rd_ptr_d];
        end

        for (int i = 0; i < int'(MUL_LAT); i++) begin
            pend_c = pend_c + CRD_W'(vld_pipe_d[i]);
        end

        // Credits count both buffered and in-flight results.
        in_ready_d  = (CRD_W'(count_d) + pend_c) < CRD_W'(FIFO_DEPTH);
        out_valid_d = (count_d != '0);
        busy_d      = (|vld_pipe_d) | (count_d != '0);
    end

    // Control state with asynchronous reset; reset drops all in-flight work.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld_pipe_q  <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            head_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ce_q        <= 1'b0;
        end else begin
            vld_pipe_q  <= vld_pipe_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            head_q      <= head_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            ce_q        <= 1'b1;
        end
    end

    // Result storage; contents are only observed through count-qualified head.
    always_ff @(posedge ap_clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_main_mul_rescale_stage.sv
// Bench for main_mul_rescale_stage: behavioural multiplier, golden rescale model,
// scoreboard queue filled on accept and drained on every output handshake.
module tb_main_mul_rescale_stage;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [41:0] in_a;
    logic [32:0] in_b;
    logic        mul_ce;
    logic [41:0] mul_din0;
    logic [32:0] mul_din1;
    logic [74:0] mul_dout = '0;
    logic        out_valid;
    logic        out_ready;
    logic [41:0] out_data;
    logic        out_sat;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int n_pop = 0;
    logic [42:0] exp_q[$];

    main_mul_rescale_stage dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .mul_ce   (mul_ce),
        .mul_din0 (mul_din0),
        .mul_din1 (mul_din1),
        .mul_dout (mul_dout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .busy     (busy)
    );

    always #5 ap_clk = ~ap_clk;

    // One-stage multiplier, deliberately not reset so stale products linger.
    always @(posedge ap_clk) begin
        if (mul_ce) mul_dout <= mul_din0 * mul_din1;
    end

    function automatic logic [42:0] golden(input logic [41:0] a, input logic [32:0] b);
        logic [127:0] p;
        p = 128'(a) * 128'(b);
        p = (p + 128'h8000_0000) >> 32;
        if (p > 128'h3FF_FFFF_FFFF) return {1'b1, 42'h3FF_FFFF_FFFF};
        return {1'b0, p[41:0]};
    endfunction

    // Scoreboard: inputs are stable between posedge+1 and the next posedge.
    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            if (in_valid && in_ready) exp_q.push_back(golden(in_a, in_b));
            if (out_valid && out_ready) begin
                total++;
                n_pop++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL scoreboard_unexpected: got data=%h sat=%0b, none expected", out_data, out_sat);
                end else begin
                    if ({out_sat, out_data} !== exp_q[0]) begin
                        bad++;
                        $display("FAIL scoreboard_data: got %h, want %h", {out_sat, out_data}, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 60) begin
            cyc();
            k++;
        end
        total++;
        if (exp_q.size() != 0 || out_valid) begin
            bad++;
            $display("FAIL %s_drain: pending=%0d out_valid=%0b, want 0/0", name, exp_q.size(), out_valid);
        end
    endtask

    // Drives one pair and waits (bounded) for its result at the head.
    task automatic run_one(input logic [41:0] a, input logic [32:0] b,
                           output logic [41:0] d, output logic s,
                           output int lat, output bit rdy, output bit to);
        cyc();
        out_ready = 1'b1;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        rdy = in_ready;
        cyc();
        in_valid = 1'b0;
        lat = 1;
        to = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) begin
                to = 1'b0;
                break;
            end
            cyc();
            lat++;
        end
        d = out_data;
        s = out_sat;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_a = '0;
        in_b = '0;
        repeat (3) cyc();
        total++;
        if ({out_valid, in_ready, busy, mul_ce} !== 4'b0000 || out_data !== 42'd0 || out_sat !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: v/r/b/ce=%b data=%h sat=%0b, want 0000/0/0",
                     {out_valid, in_ready, busy, mul_ce}, out_data, out_sat);
        end
        ap_rst_n = 1'b1;
        cyc();
        total++;
        if ({out_valid, in_ready, busy, mul_ce} !== 4'b0101) begin
            bad++;
            $display("FAIL reset_release: v/r/b/ce=%b, want 0101", {out_valid, in_ready, busy, mul_ce});
        end
    endtask

    task automatic test_basic();
        logic [41:0] d; logic s; int lat; bit rdy, to;
        run_one(42'h2_0000_0000, 33'h1_8000_0000, d, s, lat, rdy, to);
        total++;
        if (!rdy || to) begin
            bad++;
            $display("FAIL basic_handshake: ready=%0b timeout=%0b, want 1/0", rdy, to);
        end
        total++;
        if (lat !== 2) begin
            bad++;
            $display("FAIL basic_latency: got %0d cycles, want 2", lat);
        end
        total++;
        if (d !== 42'h3_0000_0000 || s !== 1'b0) begin
            bad++;
            $display("FAIL basic_value: got %h sat=%0b, want 300000000 sat=0", d, s);
        end
        drain("basic");
    endtask

    task automatic test_rounding();
        logic [41:0] d; logic s; int lat; bit rdy, to;
        run_one(42'd1, 33'h0_8000_0000, d, s, lat, rdy, to);
        total++;
        if (to || d !== 42'd1 || s !== 1'b0) begin
            bad++;
            $display("FAIL round_half_up: got %h sat=%0b to=%0b, want 1 sat=0", d, s, to);
        end
        run_one(42'd1, 33'h0_7FFF_FFFF, d, s, lat, rdy, to);
        total++;
        if (to || d !== 42'd0 || s !== 1'b0) begin
            bad++;
            $display("FAIL round_below_half: got %h sat=%0b to=%0b, want 0 sat=0", d, s, to);
        end
        drain("rounding");
    endtask

    task automatic test_saturation();
        logic [41:0] d; logic s; int lat; bit rdy, to;
        run_one(42'h3FF_FFFF_FFFF, 33'h1_FFFF_FFFF, d, s, lat, rdy, to);
        total++;
        if (to || d !== 42'h3FF_FFFF_FFFF || s !== 1'b1) begin
            bad++;
            $display("FAIL saturation: got %h sat=%0b to=%0b, want 3ffffffffff sat=1", d, s, to);
        end
        drain("saturation");
    endtask

    task automatic test_backpressure();
        int acc, pops0;
        logic [42:0] head;
        acc = 0;
        pops0 = n_pop;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            in_valid = 1'b1;
            in_a = 42'({$urandom(), $urandom()});
            in_b = 33'({$urandom(), $urandom()});
            if (in_ready) acc++;
        end
        cyc();
        in_valid = 1'b0;
        total++;
        if (acc != 4 || in_ready !== 1'b0 || out_valid !== 1'b1 || exp_q.size() != 4) begin
            bad++;
            $display("FAIL bp_fill: accepted=%0d ready=%0b valid=%0b queued=%0d, want 4/0/1/4",
                     acc, in_ready, out_valid, exp_q.size());
        end
        head = exp_q[0];
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if ({out_sat, out_data} !== head || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL bp_stable: got %h valid=%0b, want %h valid=1", {out_sat, out_data}, out_valid, head);
            end
        end
        out_ready = 1'b1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_ready_before_pop: got %0b, want 0", in_ready);
        end
        cyc();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_ready_after_pop: got %0b, want 1", in_ready);
        end
        drain("backpressure");
        total++;
        if (n_pop - pops0 != 4) begin
            bad++;
            $display("FAIL bp_count: got %0d results, want 4", n_pop - pops0);
        end
    endtask

    task automatic test_back_to_back();
        int pops0, drops, gaps;
        pops0 = n_pop;
        drops = 0;
        gaps = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (in_ready !== 1'b1) drops++;
            if (i >= 2 && out_valid !== 1'b1) gaps++;
            in_valid = 1'b1;
            in_a = (i % 7 == 0) ? 42'h3FF_FFFF_FFFF : 42'({$urandom(), $urandom()});
            in_b = 33'({$urandom(), $urandom()});
        end
        cyc();
        in_valid = 1'b0;
        if (out_valid !== 1'b1) gaps++;
        cyc();
        if (out_valid !== 1'b1) gaps++;
        total++;
        if (drops != 0) begin
            bad++;
            $display("FAIL b2b_in_ready: dropped %0d cycles, want 0", drops);
        end
        total++;
        if (gaps != 0) begin
            bad++;
            $display("FAIL b2b_throughput: %0d idle output cycles, want 0", gaps);
        end
        drain("b2b");
        total++;
        if (n_pop - pops0 != 100) begin
            bad++;
            $display("FAIL b2b_count: got %0d results, want 100", n_pop - pops0);
        end
    endtask

    task automatic test_reset_midop();
        int stray;
        stray = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            in_valid = 1'b1;
            in_a = 42'({$urandom(), $urandom()});
            in_b = 33'({$urandom(), $urandom()});
        end
        cyc();
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || out_valid !== 1'b1 || exp_q.size() != 4) begin
            bad++;
            $display("FAIL rst_setup: busy=%0b valid=%0b queued=%0d, want 1/1/4", busy, out_valid, exp_q.size());
        end
        ap_rst_n = 1'b0;
        #1;
        exp_q.delete();
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || mul_ce !== 1'b0) begin
            bad++;
            $display("FAIL rst_immediate: valid=%0b busy=%0b ready=%0b ce=%0b, want 0/0/0/0",
                     out_valid, busy, in_ready, mul_ce);
        end
        repeat (2) cyc();
        ap_rst_n = 1'b1;
        out_ready = 1'b1;
        cyc();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_ready: got %0b, want 1", in_ready);
        end
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) stray++;
            cyc();
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL rst_stale: %0d cycles with output/busy after reset, want 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        test_basic();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
